// File: rtl/prism_sp_unit_puzzle_fifo_r_unpack_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_read_interface                                                        |
// | First-word-fall-through FIFO read port: data valid while !empty.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fifo_read_interface #(
  parameter int DATA_WIDTH = 72
);
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  rd_en;

  modport master (input rd_data, input empty, output rd_en);
  modport slave  (output rd_data, output empty, input rd_en);
endinterface
`default_nettype wire

// File: rtl/prism_sp_unit_puzzle_fifo_r_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prism_sp_unit_puzzle_fifo_r_unpack                                         |
// | Splits wide FWFT FIFO entries into registered OUT_WIDTH-bit slices.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module prism_sp_unit_puzzle_fifo_r_unpack #(
  parameter  int DATA_WIDTH = 72,
  parameter  int OUT_WIDTH  = 32,
  parameter  bit MSB_FIRST  = 1'b0,
  localparam int OW_SAFE    = (OUT_WIDTH < 1) ? 1 : OUT_WIDTH,
  localparam int NWORDS     = DATA_WIDTH / OW_SAFE,
  localparam int REM        = DATA_WIDTH % OW_SAFE,
  localparam int LASTIDX    = (REM != 0) ? NWORDS : NWORDS - 1,
  localparam int IDXW       = (LASTIDX > 0) ? $clog2(LASTIDX + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_read_interface.master   fifo_r,
  input  logic                 skip,
  output logic [OW_SAFE-1:0]   out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_first,
  output logic                 out_last,
  output logic [IDXW-1:0]      idx
);

  localparam logic [IDXW-1:0] c_LAST = IDXW'(LASTIDX);
  localparam int              c_PADW = (LASTIDX + 1) * OW_SAFE;

  if (OUT_WIDTH < 1) begin : g_bad_width
    $fatal(1, "OUT_WIDTH must be >= 1");
  end

  logic [OW_SAFE-1:0] r_out;
  logic               r_valid;
  logic               r_first;
  logic               r_last;
  logic [IDXW-1:0]    r_idx;

  logic [c_PADW-1:0]  w_padded;
  logic [IDXW-1:0]    w_phys;
  logic [OW_SAFE-1:0] w_slice;
  logic               w_space;
  logic               w_load;
  logic               w_skip_pop;
  logic [IDXW-1:0]    w_idx_next;

  // Zero-extend so the partial top slice reads zeros above DATA_WIDTH.
  always_comb begin
    w_padded                   = '0;
    w_padded[DATA_WIDTH-1:0]   = fifo_r.rd_data;
  end

  if (MSB_FIRST) begin : g_msb_first
    assign w_phys = c_LAST - r_idx;
  end else begin : g_lsb_first
    assign w_phys = r_idx;
  end

  assign w_slice    = w_padded[w_phys*OW_SAFE +: OW_SAFE];
  assign w_space    = !r_valid || out_ready;
  assign w_load     = w_space && !fifo_r.empty && !skip && !rst;
  assign w_skip_pop = skip && !fifo_r.empty && !rst;
  assign w_idx_next = (r_idx == c_LAST) ? '0 : r_idx + 1'b1;

  assign fifo_r.rd_en = !rst && !fifo_r.empty && ((w_load && (r_idx == c_LAST)) || skip);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_idx   <= '0;
    end else begin
      if (w_load) begin
        r_out   <= w_slice;
        r_valid <= 1'b1;
        r_first <= (r_idx == '0);
        r_last  <= (r_idx == c_LAST);
      end else if (w_space) begin
        r_valid <= 1'b0;
      end
      // A skip pops the entry even while the output stage is stalled.
      if (w_skip_pop) begin
        r_idx <= '0;
      end else if (w_load) begin
        r_idx <= w_idx_next;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign out_first = r_first;
  assign out_last  = r_last;
  assign idx       = r_idx;

endmodule
`default_nettype wire
